shift_mix_stage: RTL
====================

SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for AES-128.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  input-valid strobe; data, final_i and round_i are sampled when start_i=1.
REQ-005 data  input  128  post-SubBytes AES state; byte 0 = data[127:120]; byte b holds state[row=b%4][col=b/4] (FIPS-197 column-major).
REQ-006 final_i  input  1  1 = last round: ShiftRows only, MixColumns bypassed.
REQ-007 round_i  input  4  round tag, carried alongside the data.
REQ-008 data_o  output  128  registered result, same byte ordering as data; drives the downstream addroundkey data input.
REQ-009 ready_o  output  1  registered output-valid strobe; drives the downstream addroundkey start_i.
REQ-010 round_o  output  4  registered round tag aligned with data_o.
REQ-011 busy_o  output  1  1 while any pipeline stage holds valid data.

Function
REQ-012 Pipeline SHALL have exactly two register stages: S1 = ShiftRows, S2 = MixColumns/bypass; latency from start_i to ready_o = 2 cycles.
REQ-013 ShiftRows: out[r][c] = in[r][(c+r) mod 4] for r,c in 0..3.
REQ-014 MixColumns per column, GF(2^8) with polynomial 0x11B: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3.
REQ-015 xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0x00), 8-bit result; 3x = xtime(x)^x.
REQ-016 final_i=1: S2 SHALL pass the ShiftRows result unchanged to data_o.
REQ-017 final_i and round_i SHALL travel with their data through both stages; no cross-talk between adjacent transactions.
REQ-018 Throughput: one transaction per cycle; back-to-back start_i accepted every cycle without bubbles or stalls.
REQ-019 No backpressure: the block has no input-ready output; it never drops or stalls accepted data.
REQ-020 ready_o SHALL be high for exactly one cycle per accepted start_i, two cycles later.
REQ-021 When ready_o=0, data_o and round_o SHALL hold their last values (no update on invalid cycles).
REQ-022 busy_o = valid_S1 | valid_S2, registered-state derived, no combinational path from start_i.
REQ-023 start_i=0 cycles SHALL insert bubbles; ready_o pattern equals start_i pattern delayed 2 cycles.

Reset
REQ-024 While rst_n=0: data_o=0, round_o=0, ready_o=0, busy_o=0, all internal valid bits and stage data registers = 0.
REQ-025 Reset assertion mid-operation SHALL discard in-flight transactions immediately; no ready_o for them after release.
REQ-026 First start_i on the first rising edge after rst_n deasserts SHALL be accepted normally.

Verification
REQ-027 FIPS-197 App. B round 1: data=d42711aee0bf98f1b8b45de51e415230, final_i=0, round_i=1 -> 2 cycles later ready_o=1, data_o=046681e5e0cb199a48f8d37a2806264c, round_o=1.
REQ-028 Same data, final_i=1, round_i=10 -> data_o=d4bf5d30e0b452aeb84111f11e2798e5, round_o=10.
REQ-029 Column db135345 (other columns 0), final_i=0 -> corresponding output column 8e4da1bc; exercises xtime reduction.
REQ-030 Back-to-back: start_i high 4 cycles with alternating final_i and round_i 1..4 -> ready_o high cycles 3-6, each output matching its own final_i/round_i; then start_i=0 -> ready_o=0, data_o held, busy_o falls after 2 cycles.
REQ-031 Reset mid-flight: start_i at cycle 0, rst_n=0 at cycle 1 for one cycle -> ready_o never asserts for that transaction, all outputs 0.
REQ-032 Random: 10k random states vs. reference model, random start_i gaps and final_i -> every output matches, ready_o count = start_i count.

Source files
------------

// File: rtl/shift_mix_stage.sv
// AES-128 ShiftRows + MixColumns round stage (MixColumns bypassed on the final round).
// Latency: 2 cycles start_i -> ready_o; accepts one transaction per cycle.
// No backpressure: every accepted transaction emerges two cycles later; never stalls.
module shift_mix_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] data,
    input  logic         final_i,
    input  logic [3:0]   round_i,
    output logic [127:0] data_o,
    output logic         ready_o,
    output logic [3:0]   round_o,
    output logic         busy_o
);

    // Byte b of the state sits at bits [127-8b -: 8]; byte b = state[row b%4][col b/4].

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column: word[31:24] is row 0, word[7:0] is row 3.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        o0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        o1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        o2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        o3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {o0, o1, o2, o3};
    endfunction

    // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c + rw) % 4) + rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    logic         s1_vld;
    logic [127:0] s1_dat;
    logic         s1_fin;
    logic [3:0]   s1_rnd;
    logic [127:0] s2_nxt;

    // Stage 1: register the ShiftRows result with its tags; data only moves on valid input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_fin <= 1'b0;
            s1_rnd <= '0;
        end else begin
            s1_vld <= start_i;
            if (start_i) begin
                s1_dat <= shift_rows(data);
                s1_fin <= final_i;
                s1_rnd <= round_i;
            end
        end
    end

    // Final round skips MixColumns and forwards the ShiftRows result untouched.
    always_comb begin
        s2_nxt = s1_dat;
        if (!s1_fin) begin
            s2_nxt = mix_columns(s1_dat);
        end
    end

    // Stage 2: output registers hold their last value on bubble cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_o <= 1'b0;
            data_o  <= '0;
            round_o <= '0;
        end else begin
            ready_o <= s1_vld;
            if (s1_vld) begin
                data_o  <= s2_nxt;
                round_o <= s1_rnd;
            end
        end
    end

    // Stage 2 valid is ready_o itself, so busy derives purely from registered state.
    assign busy_o = s1_vld | ready_o;

endmodule
